// File: rtl/scancode_sequencer.sv
// scancode_sequencer: frame tracker, watchdog, E0/F0 prefix decoder and event FIFO
// for the PS/2 serial-to-parallel scan-code converter.
//
// state      | meaning
// -----------+--------------------------------------------------
// ST_IDLE    | no prefix seen, next plain code is a make event
// ST_EXT     | E0 seen, next plain code is an extended make
// ST_BRK     | F0 seen, next plain code is a break
// ST_EXT_BRK | E0 then F0 seen, next plain code is an extended break
module scancode_sequencer #(
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int DEPTH          = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       edge_found,
    input  logic       valid_scan_code,
    input  logic [7:0] scan_code_in,
    output logic       conv_clear,
    output logic       event_valid,
    input  logic       event_ready,
    output logic [7:0] event_code,
    output logic       event_break,
    output logic       event_ext,
    output logic       err_parity,
    output logic       err_timeout,
    output logic       overflow,
    input  logic       status_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [AW:0]   PTR_ONE    = (AW + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } state_t;

    logic [3:0]    ecnt_q, ecnt_d;
    logic [TW-1:0] timer_q, timer_d;
    state_t        state_q, state_d;
    logic          conv_clear_q, conv_clear_d;
    logic          err_parity_q, err_parity_d;
    logic          err_timeout_q, err_timeout_d;
    logic          overflow_q, overflow_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [9:0]    mem_q [DEPTH];
    logic [9:0]    mem_d [DEPTH];

    logic          mid_frame;
    logic          expire;
    logic          push;
    logic [9:0]    push_data;
    logic          fifo_full;
    logic          pop;
    logic          do_write;
    logic [9:0]    head;

    // ecnt 1..10 is the only window in which the converter can stall
    assign mid_frame   = (ecnt_q != 4'd0) && (ecnt_q <= 4'd10);
    assign expire      = mid_frame && (timer_q == TIMER_LAST);
    assign fifo_full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign event_valid = (wr_ptr_q != rd_ptr_q);
    assign pop         = event_valid && event_ready;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign do_write    = push && (!fifo_full || pop);
    assign head        = mem_q[rd_ptr_q[AW-1:0]];

    assign event_code  = head[9:2];
    assign event_break = head[1];
    assign event_ext   = head[0];
    assign conv_clear  = conv_clear_q;
    assign err_parity  = err_parity_q;
    assign err_timeout = err_timeout_q;
    assign overflow    = overflow_q;

    // Frame tracking, watchdog and prefix decoding: next-state logic
    always_comb begin
        ecnt_d        = ecnt_q;
        timer_d       = '0;
        state_d       = state_q;
        conv_clear_d  = 1'b0;
        err_parity_d  = 1'b0;
        err_timeout_d = 1'b0;
        push          = 1'b0;
        push_data     = '0;
        if (expire) begin
            // an edge landing in the expiry cycle is dropped along with the frame
            ecnt_d        = 4'd0;
            conv_clear_d  = 1'b1;
            err_timeout_d = 1'b1;
            state_d       = ST_IDLE;
        end else if (ecnt_q == 4'd11) begin
            ecnt_d = 4'd0;
            if (!valid_scan_code) begin
                err_parity_d = 1'b1;
                state_d      = ST_IDLE;
            end else if (scan_code_in == 8'hE0) begin
                if (state_q == ST_IDLE) state_d = ST_EXT;
            end else if (scan_code_in == 8'hF0) begin
                if (state_q == ST_IDLE)     state_d = ST_BRK;
                else if (state_q == ST_EXT) state_d = ST_EXT_BRK;
            end else begin
                push      = 1'b1;
                push_data = {scan_code_in,
                             (state_q == ST_BRK) || (state_q == ST_EXT_BRK),
                             (state_q == ST_EXT) || (state_q == ST_EXT_BRK)};
                state_d   = ST_IDLE;
            end
        end else begin
            if (edge_found) ecnt_d = ecnt_q + 4'd1;
            if (mid_frame && !edge_found) timer_d = timer_q + TIMER_ONE;
        end
    end

    // Event FIFO and sticky overflow: next-state logic
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_write) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
        overflow_d = overflow_q;
        if (push && !do_write) overflow_d = 1'b1;
        else if (status_clr)   overflow_d = 1'b0;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ecnt_q        <= '0;
            timer_q       <= '0;
            state_q       <= ST_IDLE;
            conv_clear_q  <= 1'b0;
            err_parity_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            mem_q         <= '{default: '0};
        end else begin
            ecnt_q        <= ecnt_d;
            timer_q       <= timer_d;
            state_q       <= state_d;
            conv_clear_q  <= conv_clear_d;
            err_parity_q  <= err_parity_d;
            err_timeout_q <= err_timeout_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            mem_q         <= mem_d;
        end
    end

endmodule

// File: doc/scancode_sequencer.md
# scancode_sequencer

Controller for the PS/2 serial-to-parallel scan-code converter. It tracks the converter's 11-bit frame using the shared `edge_found` strobe, flags parity failures and stalled frames, and issues a clear to resynchronise the converter. It decodes the E0 (extended) and F0 (break) prefixes into complete key events. Events are buffered in a small FIFO and handed to the downstream key-handling logic with a valid/ready handshake.

## Interface
- `TIMEOUT_CYCLES`, default 20000: clk cycles without an `edge_found` mid-frame before the frame is abandoned.
- `DEPTH`, default 4: event FIFO depth; must be a power of 2, at least 2.
- `clk` input 1: system clock. One clock domain; all logic is on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `edge_found` input 1: one-cycle falling-edge strobe of the PS/2 clock. It is the same strobe the converter uses.
- `valid_scan_code` input 1: converter frame-complete-and-parity-good strobe.
- `scan_code_in` input 8: converter parallel scan code.
- `conv_clear` output 1: one-cycle pulse. It is ORed into the converter reset to flush a partial frame.
- `event_valid` output 1: FIFO head holds an event.
- `event_ready` input 1: consumer accepts the head this cycle.
- `event_code` output 8: head event scan code, without prefixes.
- `event_break` output 1: head event is a key release.
- `event_ext` output 1: head event carried the E0 prefix.
- `err_parity` output 1: one-cycle pulse; a frame ended without `valid_scan_code`.
- `err_timeout` output 1: one-cycle pulse; a frame stalled.
- `overflow` output 1: sticky; an event was dropped because the FIFO was full.
- `status_clr` input 1: clears `overflow`.

## Operation
- **Edge counter `ecnt` (0..11).**
  - Increments on `edge_found`.
  - When `ecnt==11`, the next cycle forces it to 0, regardless of `edge_found`.
  - This matches the converter's modulo-11 count cycle for cycle.
- **Frame check.** The check is made in the cycle where `ecnt==11`:
  - `valid_scan_code==1` gives a good code, which goes to the prefix FSM.
  - `valid_scan_code==0` pulses `err_parity` in the next cycle and sends the FSM to IDLE.
- **Watchdog.**
  - A timer counts while `1<=ecnt<=10`. It reloads to 0 on every `edge_found`, and is 0 whenever `ecnt` is 0 or 11.
  - When the timer reaches `TIMEOUT_CYCLES-1`, the block does the following in the next cycle:
    - pulses `conv_clear` and `err_timeout`;
    - clears `ecnt` and the timer;
    - sends the FSM to IDLE.
  - An `edge_found` arriving in the expiry cycle is discarded.
- **Prefix FSM.** States are IDLE, EXT, BRK and EXT_BRK. Transitions on a good code:
  - From IDLE: E0 goes to EXT; F0 goes to BRK.
  - From EXT: F0 goes to EXT_BRK; E0 stays in EXT.
  - From BRK and EXT_BRK: E0 and F0 are ignored and the state is held.
  - Any other code, in any state, pushes an event and returns to IDLE. The event is `{code, break = state in {BRK, EXT_BRK}, ext = state in {EXT, EXT_BRK}}`.
- **Event FIFO.**
  - `DEPTH` entries of 10 bits, with pointers one bit wider than the address.
  - A pop occurs when `event_valid && event_ready`.
  - Push when full:
    - without a same-cycle pop, the event is dropped and `overflow` sets;
    - with a same-cycle pop, the push succeeds and there is no overflow.
  - Empty plus push plus ready: no bypass. `event_valid` rises the next cycle.
- **`overflow`.**
  - Set has priority over `status_clr` in the same cycle.
  - Otherwise `status_clr` clears it.
- **Reset.** `rst` mid-frame or mid-sequence drops all state; no pulses are issued.
  - The integrator also resets the converter with `rst`.

## Timing
- Reset values:
  - `ecnt`, timer and FIFO pointers: 0.
  - FSM: IDLE.
  - Outputs: `event_valid`, `conv_clear`, `err_parity`, `err_timeout`, `overflow` are 0; `event_code`, `event_break`, `event_ext` are 0.
- The 11th `edge_found` at cycle t gives the `ecnt==11` and `valid_scan_code` sample at t+1.
- The FIFO write happens at the end of t+1, so `event_valid` is seen at t+2 when the FIFO was empty.
- `err_parity` is high at t+2 for one cycle.
- Timeout:
  - last edge at cycle s, so the timer is 0 at s+1;
  - expiry at s+`TIMEOUT_CYCLES`;
  - `conv_clear` and `err_timeout` high at s+`TIMEOUT_CYCLES`+1.
- Head outputs are stable while `event_valid && !event_ready`.
- Throughput: one event per cycle, in and out.

## Test plan
- Frame 0x1C, odd parity good, `ready=1`: one event `{1C,0,0}`, `event_valid` one cycle, no errors.
- Frames F0,1C then E0,F0,75: events `{1C,brk=1,ext=0}` and `{75,brk=1,ext=1}`; FSM returns to IDLE after each.
- Frame with a wrong parity bit (converter `valid` low) sent after E0: `err_parity` one pulse at t+2, no event. A following 0x74 gives `{74,0,0}` (the prefix was lost).
- 4 edges then silence, `TIMEOUT_CYCLES=50`: `conv_clear` and `err_timeout` pulse exactly 51 cycles after the 4th edge. A subsequent full frame 0x29 decodes correctly.
- `ready=0`, 5 codes 0x15,0x1D,0x24,0x2D,0x2C (`DEPTH=4`):
  - `overflow=1`;
  - draining yields 15,1D,24,2D in order;
  - `status_clr` drops `overflow`.
- FIFO full with a push and a pop in the same cycle: no overflow, count stays 4. `rst` asserted mid-frame: all outputs return to reset values the next cycle.
